// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// Sync-timer scheduler for the EtherNeco ring master: periodic sync_start pulses,
// override phase after arming, per-sync timeout supervision and saturating statistics.
module jellyvl_etherneco_synctimer_scheduler #(
  parameter int PERIOD_WIDTH   = 32,
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int COUNT_WIDTH    = 16,
  parameter int OVERRIDE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [PERIOD_WIDTH-1:0]   period,
  input  logic [TIMEOUT_WIDTH-1:0]  timeout,
  input  logic [OVERRIDE_WIDTH-1:0] override_cycles,
  output logic                      sync_start,
  output logic                      sync_override,
  input  logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic                      tx_last,
  input  logic                      res_rx_end,
  input  logic                      res_rx_error,
  output logic                      busy,
  output logic                      locked,
  output logic [COUNT_WIDTH-1:0]    sync_count,
  output logic [COUNT_WIDTH-1:0]    error_count,
  output logic [COUNT_WIDTH-1:0]    timeout_count,
  output logic [COUNT_WIDTH-1:0]    overrun_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_TX,
    ST_RESP
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0]   PC_ONE  = PERIOD_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]  TC_ONE  = TIMEOUT_WIDTH'(1);
  localparam logic [OVERRIDE_WIDTH-1:0] OVR_ONE = OVERRIDE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]    CNT_ONE = COUNT_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [PERIOD_WIDTH-1:0]   pc_q, pc_d;
  logic [TIMEOUT_WIDTH-1:0]  tc_q, tc_d;
  logic [OVERRIDE_WIDTH-1:0] ovr_q, ovr_d;
  logic                      sync_start_q, sync_start_d;
  logic                      sync_override_q, sync_override_d;
  logic                      busy_q, busy_d;
  logic                      locked_q, locked_d;
  logic [COUNT_WIDTH-1:0]    sync_cnt_q, sync_cnt_d;
  logic [COUNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [COUNT_WIDTH-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [COUNT_WIDTH-1:0]    ovrun_cnt_q, ovrun_cnt_d;

  logic [PERIOD_WIDTH-1:0]   period_m1;
  logic                      tick;
  logic                      timeout_hit;
  logic                      tx_done;
  state_t                    exit_state;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // A zero period behaves as one, so the schedule ticks every cycle.
  assign period_m1   = (period == '0) ? '0 : period - PC_ONE;
  assign tick        = (pc_q == period_m1);
  assign timeout_hit = (timeout != '0) && (tc_q == timeout - TC_ONE);
  assign tx_done     = tx_valid & tx_ready & tx_last;
  assign exit_state  = enable ? ST_ARM : ST_IDLE;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    pc_d            = pc_q;
    tc_d            = tc_q;
    ovr_d           = ovr_q;
    sync_start_d    = 1'b0;
    sync_override_d = sync_override_q;
    sync_cnt_d      = sync_cnt_q;
    err_cnt_d       = err_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    ovrun_cnt_d     = ovrun_cnt_q;

    // The free-running grid keeps going through transactions so overruns stay phase-aligned.
    if (state_q != ST_IDLE) begin
      pc_d = tick ? '0 : pc_q + PC_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ARM;
          pc_d    = period_m1;
          ovr_d   = override_cycles;
        end
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          sync_start_d    = 1'b1;
          sync_override_d = (ovr_q != '0);
          tc_d            = '0;
          state_d         = ST_TX;
        end
      end
      ST_TX: begin
        tc_d = tc_q + TC_ONE;
        if (tick) ovrun_cnt_d = sat_inc(ovrun_cnt_q);
        if (timeout_hit) begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          ovr_d     = override_cycles;
          state_d   = exit_state;
        end else if (tx_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        tc_d = tc_q + TC_ONE;
        if (tick) ovrun_cnt_d = sat_inc(ovrun_cnt_q);
        if (res_rx_end) begin
          if (res_rx_error) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else begin
            sync_cnt_d = sat_inc(sync_cnt_q);
            if (ovr_q != '0) ovr_d = ovr_q - OVR_ONE;
          end
          state_d = exit_state;
        end else if (timeout_hit) begin
          // A lost response forces the next syncs back into override.
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          ovr_d     = override_cycles;
          state_d   = exit_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      ovr_d       = override_cycles;
      sync_cnt_d  = '0;
      err_cnt_d   = '0;
      tmo_cnt_d   = '0;
      ovrun_cnt_d = '0;
    end
  end

  assign busy_d   = (state_d == ST_TX) || (state_d == ST_RESP);
  assign locked_d = (ovr_d == '0) && (state_d != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      pc_q            <= '0;
      tc_q            <= '0;
      ovr_q           <= '0;
      sync_start_q    <= 1'b0;
      sync_override_q <= 1'b0;
      busy_q          <= 1'b0;
      locked_q        <= 1'b0;
      sync_cnt_q      <= '0;
      err_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      ovrun_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      tc_q            <= tc_d;
      ovr_q           <= ovr_d;
      sync_start_q    <= sync_start_d;
      sync_override_q <= sync_override_d;
      busy_q          <= busy_d;
      locked_q        <= locked_d;
      sync_cnt_q      <= sync_cnt_d;
      err_cnt_q       <= err_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      ovrun_cnt_q     <= ovrun_cnt_d;
    end
  end

  assign sync_start    = sync_start_q;
  assign sync_override = sync_override_q;
  assign busy          = busy_q;
  assign locked        = locked_q;
  assign sync_count    = sync_cnt_q;
  assign error_count   = err_cnt_q;
  assign timeout_count = tmo_cnt_q;
  assign overrun_count = ovrun_cnt_q;

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_scheduler.sv
// Directed self-checking bench for the EtherNeco sync-timer scheduler.
module tb_jellyvl_etherneco_synctimer_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        restart;
  logic [31:0] period;
  logic [23:0] timeout;
  logic [7:0]  override_cycles;
  logic        sync_start;
  logic        sync_override;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        res_rx_end;
  logic        res_rx_error;
  logic        busy;
  logic        locked;
  logic [15:0] sync_count;
  logic [15:0] error_count;
  logic [15:0] timeout_count;
  logic [15:0] overrun_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_start = 0;
  int spacing = 0;
  int lat = 0;

  jellyvl_etherneco_synctimer_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .restart        (restart),
    .period         (period),
    .timeout        (timeout),
    .override_cycles(override_cycles),
    .sync_start     (sync_start),
    .sync_override  (sync_override),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_last        (tx_last),
    .res_rx_end     (res_rx_end),
    .res_rx_error   (res_rx_error),
    .busy           (busy),
    .locked         (locked),
    .sync_count     (sync_count),
    .error_count    (error_count),
    .timeout_count  (timeout_count),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps at least once, then until sync_start is seen or the budget runs out.
  task automatic wait_start(input int max_cycles, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (sync_start !== 1'b1 && k < max_cycles);
    check("start_seen", {31'd0, sync_start}, 1);
    spacing    = cyc - last_start;
    last_start = cyc;
  endtask

  // Handshake on the cycle after the start, resp_delay idle cycles, then the response.
  task automatic do_txn(input int resp_delay, input logic err, input logic rst_pulse);
    tx_valid = 1'b1; tx_ready = 1'b1; tx_last = 1'b1;
    step();
    tx_valid = 1'b0; tx_ready = 1'b0; tx_last = 1'b0;
    check("pulse_width", {31'd0, sync_start}, 0);
    repeat (resp_delay) step();
    res_rx_end = 1'b1; res_rx_error = err; restart = rst_pulse;
    step();
    res_rx_end = 1'b0; res_rx_error = 1'b0; restart = 1'b0;
  endtask

  initial begin
    int starts;
    reset = 1'b0; enable = 1'b0; restart = 1'b0;
    period = 32'd20; timeout = 24'd0; override_cycles = 8'd2;
    tx_valid = 1'b0; tx_ready = 1'b0; tx_last = 1'b0;
    res_rx_end = 1'b0; res_rx_error = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_sync_start", {31'd0, sync_start}, 0);
    check("rst_override", {31'd0, sync_override}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_sync_count", {16'd0, sync_count}, 0);
    check("rst_overrun_count", {16'd0, overrun_count}, 0);
    reset = 1'b1;
    step();

    // Period 20, two override syncs, 5-cycle transactions
    enable = 1'b1;
    wait_start(50, lat);
    check("first_start_latency", lat, 2);
    check("t1_override0", {31'd0, sync_override}, 1);
    check("t1_busy_in_tx", {31'd0, busy}, 1);
    do_txn(3, 1'b0, 1'b0);
    check("t1_busy_after", {31'd0, busy}, 0);
    check("t1_locked_after1", {31'd0, locked}, 0);
    for (int i = 1; i < 4; i++) begin
      wait_start(50, lat);
      check("t1_spacing", spacing, 20);
      check("t1_override", {31'd0, sync_override}, (i < 2) ? 1 : 0);
      do_txn(3, 1'b0, 1'b0);
      if (i == 1) check("t1_locked_after2", {31'd0, locked}, 1);
    end
    check("t1_sync_count", {16'd0, sync_count}, 4);

    // Back to IDLE, clear, rearm at period 10 with a single override sync
    enable = 1'b0;
    step();
    check("idle_unlocked", {31'd0, locked}, 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_clears", {16'd0, sync_count}, 0);
    period = 32'd10; override_cycles = 8'd1; enable = 1'b1;

    // Response 25 cycles late: two skipped ticks, next start on the grid
    wait_start(50, lat);
    check("t2_override", {31'd0, sync_override}, 1);
    do_txn(23, 1'b0, 1'b0);
    check("t2_overrun", {16'd0, overrun_count}, 2);
    check("t2_locked", {31'd0, locked}, 1);
    timeout = 24'd8;
    wait_start(50, lat);
    check("t2_spacing", spacing, 30);
    check("t2_override_locked", {31'd0, sync_override}, 0);

    // Timeout 8 with no tx_last
    repeat (7) step();
    check("t3_no_timeout_yet", {16'd0, timeout_count}, 0);
    check("t3_busy_before", {31'd0, busy}, 1);
    step();
    check("t3_timeout_count", {16'd0, timeout_count}, 1);
    check("t3_busy_after", {31'd0, busy}, 0);
    check("t3_unlocked", {31'd0, locked}, 0);
    wait_start(50, lat);
    check("t3_spacing", spacing, 10);
    check("t3_resync_override", {31'd0, sync_override}, 1);

    // Error response leaves sync_count and ovr alone
    do_txn(3, 1'b1, 1'b0);
    check("t4_error_count", {16'd0, error_count}, 1);
    check("t4_sync_count", {16'd0, sync_count}, 1);
    check("t4_still_unlocked", {31'd0, locked}, 0);
    wait_start(50, lat);
    check("t4_override_kept", {31'd0, sync_override}, 1);
    do_txn(3, 1'b0, 1'b0);
    check("t4_sync_count2", {16'd0, sync_count}, 2);
    check("t4_locked", {31'd0, locked}, 1);

    // Response on the same cycle the timeout would fire
    wait_start(50, lat);
    check("t5_override", {31'd0, sync_override}, 0);
    do_txn(6, 1'b0, 1'b0);
    check("t5_timeout_count", {16'd0, timeout_count}, 1);
    check("t5_sync_count", {16'd0, sync_count}, 3);

    // Restart together with a successful response
    wait_start(50, lat);
    do_txn(3, 1'b0, 1'b1);
    check("t5r_sync_count", {16'd0, sync_count}, 0);
    check("t5r_error_count", {16'd0, error_count}, 0);
    check("t5r_timeout_count", {16'd0, timeout_count}, 0);
    check("t5r_overrun_count", {16'd0, overrun_count}, 0);
    check("t5r_ovr_reloaded", {31'd0, locked}, 0);

    // enable dropped while waiting for the response
    wait_start(50, lat);
    check("t6_override", {31'd0, sync_override}, 1);
    tx_valid = 1'b1; tx_ready = 1'b1; tx_last = 1'b1;
    step();
    tx_valid = 1'b0; tx_ready = 1'b0; tx_last = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    check("t6_busy_resp", {31'd0, busy}, 1);
    res_rx_end = 1'b1;
    step();
    res_rx_end = 1'b0;
    check("t6_busy_idle", {31'd0, busy}, 0);
    check("t6_sync_count", {16'd0, sync_count}, 1);
    check("t6_locked_idle", {31'd0, locked}, 0);
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sync_start === 1'b1) starts++;
    end
    check("t6_no_starts", starts, 0);

    // Asynchronous reset in the middle of TX
    enable = 1'b1;
    wait_start(50, lat);
    check("t7_start_latency", lat, 2);
    check("t7_override_before", {31'd0, sync_override}, 1);
    step();
    reset = 1'b0;
    #1;
    check("t7_busy", {31'd0, busy}, 0);
    check("t7_override", {31'd0, sync_override}, 0);
    check("t7_sync_count", {16'd0, sync_count}, 0);
    check("t7_sync_start", {31'd0, sync_start}, 0);

    // period 0 ticks every cycle
    step();
    period = 32'd0;
    reset = 1'b1;
    wait_start(50, lat);
    check("t8_start_latency", lat, 2);
    do_txn(0, 1'b0, 1'b0);
    wait_start(50, lat);
    check("t8_spacing", spacing, 3);
    check("t8_overrun", {16'd0, overrun_count}, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
